// File: rtl/mmio_adsr.sv
// mmio_adsr: MMIO-mapped ADSR envelope sequencer for the DDFS sound core.
// Software programs slopes, sustain level and sustain time, then pulses
// start. A 32-bit amplitude accumulator ramps ATTACK->DECAY->SUSTAIN->RELEASE.
// Its top 16 bits drive the envelope input of the DDFS.
module mmio_adsr (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        write,
    input  logic        read,
    input  logic [4:0]  addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic [15:0] env_out,
    output logic        busy
);

    localparam logic [31:0] AMP_MAX = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // Sustain level can never exceed the amplitude ceiling.
    function automatic logic [31:0] clamp_level(input logic [31:0] value);
        logic [31:0] result;
        if (value > AMP_MAX) begin
            result = AMP_MAX;
        end else begin
            result = value;
        end
        return result;
    endfunction

    state_t      state_r;
    logic [31:0] amp_r;
    logic [31:0] timer_r;
    logic [31:0] atk_step_r;
    logic [31:0] dec_step_r;
    logic [31:0] sus_lvl_r;
    logic [31:0] sus_time_r;
    logic [31:0] rel_step_r;

    logic        wr_s;
    logic        start_s;
    logic        abort_s;
    logic [32:0] atk_sum_s;
    logic [32:0] dec_limit_s;
    logic        atk_done_s;
    logic        dec_done_s;
    logic        rel_done_s;
    logic        read_unused_s;

    // Reads have no side effects; the strobe is intentionally ignored.
    assign read_unused_s = read;

    assign wr_s    = cs & write;
    assign start_s = wr_s && (addr[2:0] == 3'd5) && write_data[0];
    assign abort_s = wr_s && (addr[2:0] == 3'd5) && write_data[1];

    // 33-bit intermediates keep the comparisons free of wrap-around.
    assign atk_sum_s   = {1'b0, amp_r} + {1'b0, atk_step_r};
    assign dec_limit_s = {1'b0, sus_lvl_r} + {1'b0, dec_step_r};
    assign atk_done_s  = (atk_step_r == 32'd0) || (atk_sum_s >= {1'b0, AMP_MAX});
    assign dec_done_s  = (dec_step_r == 32'd0) || ({1'b0, amp_r} <= dec_limit_s);
    assign rel_done_s  = (rel_step_r == 32'd0) || (amp_r <= rel_step_r);

    assign env_out   = amp_r[31:16];
    assign busy      = (state_r != ST_IDLE);
    assign read_data = {13'd0, state_r, amp_r[31:16]};

    // Configuration registers written from the bus; ctrl (5) and 6/7 are not stored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            atk_step_r <= 32'd0;
            dec_step_r <= 32'd0;
            sus_lvl_r  <= 32'd0;
            sus_time_r <= 32'd0;
            rel_step_r <= 32'd0;
        end else if (wr_s) begin
            case (addr[2:0])
                3'd0:    atk_step_r <= write_data;
                3'd1:    dec_step_r <= write_data;
                3'd2:    sus_lvl_r  <= clamp_level(write_data);
                3'd3:    sus_time_r <= write_data;
                3'd4:    rel_step_r <= write_data;
                default: ;
            endcase
        end
    end

    // Envelope FSM: abort beats start, start beats the normal phase step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            amp_r   <= 32'd0;
            timer_r <= 32'd0;
        end else if (abort_s) begin
            state_r <= ST_IDLE;
            amp_r   <= 32'd0;
        end else if (start_s) begin
            // Retrigger from the current level to avoid an audible click.
            state_r <= ST_ATTACK;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    amp_r <= 32'd0;
                end
                ST_ATTACK: begin
                    if (atk_done_s) begin
                        amp_r   <= AMP_MAX;
                        state_r <= ST_DECAY;
                    end else begin
                        amp_r <= atk_sum_s[31:0];
                    end
                end
                ST_DECAY: begin
                    if (dec_done_s) begin
                        amp_r   <= sus_lvl_r;
                        timer_r <= 32'd0;
                        state_r <= ST_SUSTAIN;
                    end else begin
                        amp_r <= amp_r - dec_step_r;
                    end
                end
                ST_SUSTAIN: begin
                    if (timer_r >= sus_time_r) begin
                        state_r <= ST_RELEASE;
                    end else begin
                        timer_r <= timer_r + 32'd1;
                    end
                end
                ST_RELEASE: begin
                    if (rel_done_s) begin
                        amp_r   <= 32'd0;
                        state_r <= ST_IDLE;
                    end else begin
                        amp_r <= amp_r - rel_step_r;
                    end
                end
                default: begin
                    amp_r   <= 32'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_adsr.sv
// Self-checking bench for mmio_adsr: directed envelope scenarios with
// hard-coded expectations plus randomized bus traffic, all compared each
// cycle against a behavioural model built from the envelope rules.
module tb_mmio_adsr;

    logic        clk;
    logic        reset_n;
    logic        cs;
    logic        write;
    logic        read;
    logic [4:0]  addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [15:0] env_out;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    localparam longint MAXV = 64'h7FFF_FFFF;

    // Behavioural model: phase number, amplitude and config as wide integers.
    int     m_state;
    longint m_amp, m_timer, m_atk, m_dec, m_sus, m_stime, m_rel;

    logic [15:0] exp2 [0:22] = '{
        16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000, 16'h6000, 16'h7000,
        16'h7FFF, 16'h77FF, 16'h6FFF, 16'h67FF, 16'h5FFF, 16'h57FF, 16'h4FFF, 16'h47FF,
        16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h2000, 16'h0000};

    mmio_adsr dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cs         (cs),
        .write      (write),
        .read       (read),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .env_out    (env_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_amp = 0; m_timer = 0;
        m_atk = 0; m_dec = 0; m_sus = 0; m_stime = 0; m_rel = 0;
    endtask

    // One clock edge of the envelope rules, using config as it stood before the edge.
    task automatic model_edge();
        bit     wr;
        bit     st;
        bit     ab;
        longint wd;
        wr = cs && write;
        st = wr && (addr[2:0] == 3'd5) && write_data[0];
        ab = wr && (addr[2:0] == 3'd5) && write_data[1];
        wd = {32'd0, write_data};
        if (ab) begin
            m_state = 0; m_amp = 0;
        end else if (st) begin
            m_state = 1;
        end else begin
            if (m_state == 1) begin
                if (m_atk == 0 || m_amp + m_atk >= MAXV) begin m_amp = MAXV; m_state = 2; end
                else m_amp = m_amp + m_atk;
            end else if (m_state == 2) begin
                if (m_dec == 0 || m_amp <= m_sus + m_dec) begin m_amp = m_sus; m_timer = 0; m_state = 3; end
                else m_amp = m_amp - m_dec;
            end else if (m_state == 3) begin
                if (m_timer >= m_stime) m_state = 4;
                else m_timer = m_timer + 1;
            end else if (m_state == 4) begin
                if (m_rel == 0 || m_amp <= m_rel) begin m_amp = 0; m_state = 0; end
                else m_amp = m_amp - m_rel;
            end else begin
                m_amp = 0;
            end
        end
        if (wr) begin
            if (addr[2:0] == 3'd0) m_atk = wd;
            if (addr[2:0] == 3'd1) m_dec = wd;
            if (addr[2:0] == 3'd2) m_sus = (wd > MAXV) ? MAXV : wd;
            if (addr[2:0] == 3'd3) m_stime = wd;
            if (addr[2:0] == 3'd4) m_rel = wd;
        end
    endtask

    task automatic model_check(input string tag);
        logic [31:0] a32;
        logic [2:0]  s3;
        a32 = m_amp[31:0];
        s3  = 3'(m_state);
        chk({tag, "_rd"}, read_data, {13'd0, s3, a32[31:16]});
        chk({tag, "_env"}, {16'd0, env_out}, {16'd0, a32[31:16]});
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, (m_state != 0)});
    endtask

    // Advance one clock, update the model at the edge, check on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_check("model");
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; write_data = d;
        tick();
        cs = 1'b0; write = 1'b0; addr = 5'd0; write_data = 32'd0;
    endtask

    task automatic prog(input logic [31:0] atk, input logic [31:0] dec, input logic [31:0] sus,
                        input logic [31:0] tim, input logic [31:0] rel);
        wr(5'd0, atk); wr(5'd1, dec); wr(5'd2, sus); wr(5'd3, tim); wr(5'd4, rel);
    endtask

    initial begin
        reset_n = 1'b0; cs = 1'b0; write = 1'b0; read = 1'b0;
        addr = 5'd0; write_data = 32'd0;
        model_reset();
        #12;
        chk("reset_rd", read_data, 32'd0);
        chk("reset_env", {16'd0, env_out}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset asserted mid-ATTACK returns everything to zero asynchronously.
        prog(32'h1000_0000, 32'h0800_0000, 32'h4000_0000, 32'd3, 32'h2000_0000);
        wr(5'd5, 32'd1);
        ticks(3);
        chk("pre_reset_env", {16'd0, env_out}, 32'h0000_3000);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rd", read_data, 32'd0);
        chk("async_env", {16'd0, env_out}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        // Config is zero after reset: every phase is a one-cycle jump.
        wr(5'd5, 32'd1);
        chk("zcfg_a", read_data, {13'd0, 3'd1, 16'h0000});
        tick(); chk("zcfg_d", read_data, {13'd0, 3'd2, 16'h7FFF});
        tick(); chk("zcfg_s", read_data, {13'd0, 3'd3, 16'h0000});
        tick(); chk("zcfg_r", read_data, {13'd0, 3'd4, 16'h0000});
        tick(); chk("zcfg_i", read_data, 32'd0);

        // Full envelope with the reference slopes.
        prog(32'h1000_0000, 32'h0800_0000, 32'h4000_0000, 32'd3, 32'h2000_0000);
        wr(5'd5, 32'd1);
        chk("s2_env", {16'd0, env_out}, {16'd0, exp2[0]});
        for (int i = 1; i < 23; i++) begin
            tick();
            chk("s2_env", {16'd0, env_out}, {16'd0, exp2[i]});
        end
        chk("s2_idle_busy", {31'd0, busy}, 32'd0);

        // All steps zero: one cycle per phase.
        prog(32'd0, 32'd0, 32'h2000_0000, 32'd0, 32'd0);
        wr(5'd5, 32'd1);
        chk("s3_a", read_data, {13'd0, 3'd1, 16'h0000});
        tick(); chk("s3_d", read_data, {13'd0, 3'd2, 16'h7FFF});
        tick(); chk("s3_s", read_data, {13'd0, 3'd3, 16'h2000});
        tick(); chk("s3_r", read_data, {13'd0, 3'd4, 16'h2000});
        tick(); chk("s3_i", read_data, 32'd0);

        // Saturation and sustain-level clamp (zero-length decay at MAX).
        prog(32'hFFFF_FFFF, 32'h1000_0000, 32'hFFFF_FFFF, 32'd2, 32'h4000_0000);
        wr(5'd5, 32'd1);
        tick(); chk("s4_sat", read_data, {13'd0, 3'd2, 16'h7FFF});
        tick(); chk("s4_clamp", read_data, {13'd0, 3'd3, 16'h7FFF});
        ticks(8);
        chk("s4_done", read_data, 32'd0);

        // Retrigger from SUSTAIN continues from the held level.
        prog(32'h1000_0000, 32'h0800_0000, 32'h4000_0000, 32'd3, 32'h2000_0000);
        wr(5'd5, 32'd1);
        ticks(17);
        chk("s5_sus", read_data, {13'd0, 3'd3, 16'h4000});
        wr(5'd5, 32'd1);
        chk("s5_retrig", read_data, {13'd0, 3'd1, 16'h4000});
        tick(); chk("s5_next", {16'd0, env_out}, 32'h0000_5000);
        ticks(30);
        chk("s5_done", {31'd0, busy}, 32'd0);

        // Abort+start during DECAY, then ignored writes, then a clean restart.
        wr(5'd5, 32'd1);
        ticks(9);
        chk("s6_decay", read_data, {13'd0, 3'd2, 16'h77FF});
        wr(5'd5, 32'd3);
        chk("s6_abort", read_data, 32'd0);
        wr(5'd6, 32'hFFFF_FFFF);
        wr(5'd7, 32'hFFFF_FFFF);
        wr(5'd13, 32'hFFFF_FFFF);
        cs = 1'b0; write = 1'b1; addr = 5'd0; write_data = 32'hFFFF_FFFF;
        tick();
        addr = 5'd5; write_data = 32'd1;
        tick();
        write = 1'b0;
        chk("s6_ignored", read_data, 32'd0);
        wr(5'd5, 32'd1);
        tick(); chk("s6_restart", {16'd0, env_out}, 32'h0000_1000);
        ticks(30);

        // Randomized bus traffic against the model.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            read = 1'($urandom_range(0, 1));
            if (r < 10) begin
                wr(5'($urandom_range(0, 4)), $urandom >> $urandom_range(0, 12));
            end else if (r < 13) begin
                wr(5'd3, 32'($urandom_range(0, 12)));
            end else if (r < 16) begin
                wr(5'd5, 32'($urandom_range(0, 3)));
            end else if (r < 18) begin
                wr(5'($urandom_range(0, 31)), $urandom);
            end else if (r < 20) begin
                cs = 1'b0; write = 1'b1; addr = 5'($urandom_range(0, 7)); write_data = $urandom;
                tick();
                write = 1'b0;
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
